// File: rtl/ob_drv.sv
// Order-book driver: registers upstream commands toward the order book,
// tracks commands in flight, buffers responses in a small FIFO and runs a
// watchdog that parks the block in an error state when a response is overdue.

package ob_pkg;
  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  id;
    logic [15:0] qty;
  } cmd_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [1:0]  status;
    logic [15:0] fill;
  } rsp_t;
endpackage

module ob_drv #(
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned RSP_N        = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_vld,
  input  ob_pkg::cmd_t                      in_cmd,
  output logic                              in_rdy,
  output logic                              cmd_vld_r,
  output ob_pkg::cmd_t                      cmd_r,
  input  logic                              cmd_full_r,
  input  logic                              rsp_vld,
  input  ob_pkg::rsp_t                      rsp,
  output logic                              rsp_accept,
  output logic                              out_vld,
  output ob_pkg::rsp_t                      out_rsp,
  input  logic                              out_rdy,
  input  logic                              err_clr,
  output logic                              err_timeout,
  output logic                              err_unexp_r,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_r,
  output logic [31:0]                       cmd_cnt_r,
  output logic [31:0]                       rsp_cnt_r
);

  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned PW = $clog2(RSP_N);
  localparam int unsigned CW = $clog2(RSP_N + 1);
  localparam logic [IW-1:0] MAX_I = IW'(MAX_INFLIGHT);
  localparam logic [15:0]   TMO   = 16'(TIMEOUT);
  localparam logic [CW-1:0] DEPTH = CW'(RSP_N);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;

  state_t        state;
  logic [15:0]   wd;
  logic [15:0]   wd_nxt;
  logic [IW-1:0] inflight_nxt;
  logic          issue;
  logic          push;
  logic          pop;
  logic          clr_err;
  logic          unexp_set;

  ob_pkg::rsp_t  mem [RSP_N];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;

  assign in_rdy      = (state != ST_ERR) & ~cmd_full_r & (inflight_r < MAX_I);
  assign rsp_accept  = (cnt != DEPTH);
  assign out_vld     = (cnt != '0);
  assign out_rsp     = mem[rp];
  assign err_timeout = (state == ST_ERR);

  assign issue   = in_vld & in_rdy;
  assign push    = rsp_vld & rsp_accept;
  assign pop     = out_vld & out_rdy;
  assign clr_err = err_clr & (state == ST_ERR);

  // Next in-flight count, unexpected-response detection and watchdog value
  always_comb begin
    inflight_nxt = inflight_r;
    unexp_set    = 1'b0;
    wd_nxt       = wd;
    if (clr_err) begin
      inflight_nxt = '0;
    end else if (issue && !push) begin
      inflight_nxt = inflight_r + IW'(1);
    end else if (push && !issue) begin
      if (inflight_r == '0) unexp_set = 1'b1;
      else                  inflight_nxt = inflight_r - IW'(1);
    end
    if (clr_err || inflight_r == '0 || push) wd_nxt = '0;
    else if (wd < TMO)                        wd_nxt = wd + 16'd1;
  end

  // Control FSM, command register, in-flight accounting and counters.
  // The error state is entered on the edge where the watchdog reaches
  // TIMEOUT, so err_timeout rises TIMEOUT cycles after the last activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_vld_r   <= 1'b0;
      cmd_r       <= '0;
      inflight_r  <= '0;
      wd          <= '0;
      err_unexp_r <= 1'b0;
      cmd_cnt_r   <= '0;
      rsp_cnt_r   <= '0;
    end else begin
      cmd_vld_r   <= issue;
      if (issue) cmd_r <= in_cmd;
      inflight_r  <= inflight_nxt;
      wd          <= wd_nxt;
      err_unexp_r <= err_clr ? 1'b0 : (err_unexp_r | unexp_set);
      if (issue) cmd_cnt_r <= cmd_cnt_r + 32'd1;
      if (push)  rsp_cnt_r <= rsp_cnt_r + 32'd1;
      unique case (state)
        ST_IDLE: if (issue) state <= ST_BUSY;
        ST_BUSY: begin
          if (wd_nxt == TMO)           state <= ST_ERR;
          else if (inflight_nxt == '0) state <= ST_IDLE;
        end
        ST_ERR:  if (err_clr) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= rsp;
  end

endmodule

// File: tb/tb_ob_drv.sv
// Self-checking bench for ob_drv: a response scoreboard follows the FIFO,
// directed sequences cover issue, backpressure, buffering, watchdog and reset.
module tb_ob_drv;

  localparam int unsigned MAXI = 8;
  localparam int unsigned RN   = 4;
  localparam int unsigned TMO  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld;
  ob_pkg::cmd_t in_cmd;
  logic         in_rdy;
  logic         cmd_vld_r;
  ob_pkg::cmd_t cmd_r;
  logic         cmd_full_r;
  logic         rsp_vld;
  ob_pkg::rsp_t rsp;
  logic         rsp_accept;
  logic         out_vld;
  ob_pkg::rsp_t out_rsp;
  logic         out_rdy;
  logic         err_clr;
  logic         err_timeout;
  logic         err_unexp_r;
  logic [3:0]   inflight_r;
  logic [31:0]  cmd_cnt_r;
  logic [31:0]  rsp_cnt_r;

  ob_drv #(.MAX_INFLIGHT(MAXI), .RSP_N(RN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_cmd(in_cmd), .in_rdy(in_rdy),
    .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(cmd_full_r),
    .rsp_vld(rsp_vld), .rsp(rsp), .rsp_accept(rsp_accept),
    .out_vld(out_vld), .out_rsp(out_rsp), .out_rdy(out_rdy),
    .err_clr(err_clr), .err_timeout(err_timeout), .err_unexp_r(err_unexp_r),
    .inflight_r(inflight_r), .cmd_cnt_r(cmd_cnt_r), .rsp_cnt_r(rsp_cnt_r)
  );

  always #5 clk = ~clk;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;
  int unsigned  m_rsp_cnt = 0;
  ob_pkg::rsp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ob_pkg::cmd_t mk_cmd(input int unsigned i);
    ob_pkg::cmd_t c;
    c.op  = 2'(i);
    c.id  = 8'(i + 16);
    c.qty = 16'(i * 37 + 5);
    return c;
  endfunction

  function automatic ob_pkg::rsp_t mk_rsp(input int unsigned i);
    ob_pkg::rsp_t r;
    r.id     = 8'(i * 3 + 1);
    r.status = 2'(i + 1);
    r.fill   = 16'(i * 101 + 7);
    return r;
  endfunction

  // One clock: check FIFO handshake against the scoreboard, then advance.
  task automatic step();
    bit m_push;
    bit m_pop;
    m_push = rsp_vld && (exp_q.size() < RN);
    m_pop  = out_rdy && (exp_q.size() > 0);
    check("rsp_accept", 64'(rsp_accept), 64'(exp_q.size() < RN));
    check("out_vld", 64'(out_vld), 64'(exp_q.size() > 0));
    if (m_pop) begin
      check("out_rsp", 64'(out_rsp), 64'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (m_push) begin
      exp_q.push_back(rsp);
      m_rsp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned guard = 0;
    rsp_vld = 1'b0;
    out_rdy = 1'b1;
    while (exp_q.size() > 0 && guard < 20) begin
      step();
      guard++;
    end
    out_rdy = 1'b0;
    check("drain_empty", 64'(out_vld), 64'(0));
  endtask

  task automatic chk_reset();
    check("rst_cmd_vld", 64'(cmd_vld_r), 64'(0));
    check("rst_cmd_r", 64'(cmd_r), 64'(0));
    check("rst_inflight", 64'(inflight_r), 64'(0));
    check("rst_out_vld", 64'(out_vld), 64'(0));
    check("rst_rsp_accept", 64'(rsp_accept), 64'(1));
    check("rst_err_to", 64'(err_timeout), 64'(0));
    check("rst_err_unexp", 64'(err_unexp_r), 64'(0));
    check("rst_cmd_cnt", 64'(cmd_cnt_r), 64'(0));
    check("rst_rsp_cnt", 64'(rsp_cnt_r), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_cmd = '0; cmd_full_r = 1'b0;
    rsp_vld = 1'b0; rsp = '0; out_rdy = 1'b0; err_clr = 1'b0;
    #3;
    chk_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Three back-to-back issues
    in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_cmd = mk_cmd(i);
      step();
      check("b2b_cmd_vld", 64'(cmd_vld_r), 64'(1));
      check("b2b_cmd_r", 64'(cmd_r), 64'(mk_cmd(i)));
    end
    in_vld = 1'b0;
    check("b2b_inflight", 64'(inflight_r), 64'(3));
    check("b2b_cmd_cnt", 64'(cmd_cnt_r), 64'(3));
    step();
    check("idle_cmd_vld", 64'(cmd_vld_r), 64'(0));
    check("hold_cmd_r", 64'(cmd_r), 64'(mk_cmd(2)));

    // Ingress full blocks issue
    cmd_full_r = 1'b1;
    #1 check("full_in_rdy", 64'(in_rdy), 64'(0));
    cmd_full_r = 1'b0;
    #1 check("notfull_in_rdy", 64'(in_rdy), 64'(1));

    // Answer the three and read them back in order
    for (int i = 0; i < 3; i++) begin
      rsp = mk_rsp(i); rsp_vld = 1'b1;
      step();
    end
    rsp_vld = 1'b0;
    check("rsp_inflight0", 64'(inflight_r), 64'(0));
    check("rsp_cnt3", 64'(rsp_cnt_r), 64'(m_rsp_cnt));
    drain();

    // Fill to MAX_INFLIGHT, then response frees one slot
    in_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_cmd = mk_cmd(10 + i);
      step();
    end
    check("max_inflight", 64'(inflight_r), 64'(8));
    check("max_in_rdy", 64'(in_rdy), 64'(0));
    step();
    check("max_hold", 64'(inflight_r), 64'(8));
    rsp = mk_rsp(20); rsp_vld = 1'b1;
    step();
    check("max_freed", 64'(inflight_r), 64'(7));
    check("max_rdy_again", 64'(in_rdy), 64'(1));
    rsp = mk_rsp(21);
    in_cmd = mk_cmd(30);
    step();
    check("same_cycle_inflight", 64'(inflight_r), 64'(7));
    rsp_vld = 1'b0;
    step();
    in_vld = 1'b0;
    check("refill_inflight", 64'(inflight_r), 64'(8));
    check("refill_cmd_cnt", 64'(cmd_cnt_r), 64'(13));
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rsp = mk_rsp(40 + i); rsp_vld = 1'b1;
      step();
    end
    rsp_vld = 1'b0;
    check("max_drained", 64'(inflight_r), 64'(0));
    drain();

    // Buffer full with out_rdy low, pop does not bypass full
    in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_cmd = mk_cmd(50 + i);
      step();
    end
    in_vld = 1'b0;
    out_rdy = 1'b0;
    rsp_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rsp = mk_rsp(60 + i);
      step();
    end
    rsp = mk_rsp(64);
    step();
    check("fifo_full_inflight", 64'(inflight_r), 64'(1));
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    step();
    rsp_vld = 1'b0;
    check("fifo_5th_inflight", 64'(inflight_r), 64'(0));
    drain();

    // Unexpected response with nothing in flight
    rsp = mk_rsp(70); rsp_vld = 1'b1;
    step();
    rsp_vld = 1'b0;
    check("unexp_flag", 64'(err_unexp_r), 64'(1));
    check("unexp_inflight", 64'(inflight_r), 64'(0));
    check("unexp_rsp_cnt", 64'(rsp_cnt_r), 64'(m_rsp_cnt));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("unexp_cleared", 64'(err_unexp_r), 64'(0));
    drain();

    // Watchdog timeout and recovery, with a response during err_clr
    in_vld = 1'b1; in_cmd = mk_cmd(80);
    step();
    in_vld = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("wd_before", 64'(err_timeout), 64'(0));
    step();
    check("wd_err", 64'(err_timeout), 64'(1));
    check("wd_in_rdy", 64'(in_rdy), 64'(0));
    check("wd_inflight", 64'(inflight_r), 64'(1));
    err_clr = 1'b1; rsp = mk_rsp(81); rsp_vld = 1'b1;
    step();
    err_clr = 1'b0; rsp_vld = 1'b0;
    check("clr_err_to", 64'(err_timeout), 64'(0));
    check("clr_inflight", 64'(inflight_r), 64'(0));
    check("clr_in_rdy", 64'(in_rdy), 64'(1));
    check("clr_unexp", 64'(err_unexp_r), 64'(0));
    check("clr_rsp_cnt", 64'(rsp_cnt_r), 64'(m_rsp_cnt));
    drain();

    // Asynchronous reset mid-operation
    in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_cmd = mk_cmd(90 + i);
      step();
    end
    in_vld = 1'b0;
    rsp_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rsp = mk_rsp(90 + i);
      step();
    end
    rsp_vld = 1'b0;
    check("pre_rst_inflight", 64'(inflight_r), 64'(2));
    check("pre_rst_out_vld", 64'(out_vld), 64'(1));
    #2 rst = 1'b1;
    #1 chk_reset();
    exp_q.delete();
    m_rsp_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    in_vld = 1'b1; in_cmd = mk_cmd(99);
    step();
    in_vld = 1'b0;
    check("post_rst_cmd_vld", 64'(cmd_vld_r), 64'(1));
    check("post_rst_cmd_r", 64'(cmd_r), 64'(mk_cmd(99)));
    check("post_rst_cmd_cnt", 64'(cmd_cnt_r), 64'(1));
    check("post_rst_inflight", 64'(inflight_r), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
